decode_stage: RTL and testbench

- Registered RV64I/RV32I decode stage between fetch and issue.
- Accepts a fetch bundle of FETCH_BITS bits holding FETCH_BITS/32 instructions, buffers it, and issues one decoded instruction per out handshake.
- Outputs carry sign-extended immediates, register indices, class flags and an illegal flag.
- Valid/ready on both sides; a flush input drops in-flight work.

---
 rtl/decode_stage.sv | 248 ++++++++++++++++++++++++
 tb/tb_decode_stage.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : decode_stage
// Purpose  : Registered RV32I/RV64I decode stage. Buffers one fetch bundle and
//            issues one decoded instruction per out handshake. Defining
//            DECODE_TRACE_EN adds a simulation-only handshake trace.
// Revision : 1.0
// ============================================================================
module decode_stage #(
    parameter int XLEN       = 64,
    parameter int FETCH_BITS = 64,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [FETCH_BITS-1:0] in_bundle,
    input  logic [XLEN-1:0]       in_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       out_pc,
    output logic [31:0]           out_inst,
    output logic [4:0]            out_rd,
    output logic [4:0]            out_rs1,
    output logic [4:0]            out_rs2,
    output logic [XLEN-1:0]       out_imm,
    output logic [3:0]            out_class,
    output logic [2:0]            out_funct3,
    output logic                  out_alt,
    output logic                  out_illegal,
    output logic [CNT_W-1:0]      decoded_count
);

    localparam int c_slots  = FETCH_BITS / 32;
    localparam int c_slot_w = (c_slots > 1) ? $clog2(c_slots) : 1;
    localparam int c_off_w  = $clog2(FETCH_BITS / 8);
    localparam bit c_rv64   = (XLEN == 64);

    localparam logic [c_slot_w-1:0] c_last_slot = c_slot_w'(c_slots - 1);
    localparam logic [c_slot_w-1:0] c_slot_one  = c_slot_w'(1);
    localparam logic [XLEN-1:0]     c_base_mask = {{(XLEN-c_off_w){1'b1}}, {c_off_w{1'b0}}};
    localparam logic [3:0]          c_cls_none  = 4'd15;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [FETCH_BITS-1:0]   r_bundle;
    logic [XLEN-1:0]         r_base;
    logic [c_slot_w-1:0]     r_slot;
    logic [CNT_W-1:0]        r_count;

    logic                    w_fire;
    logic                    w_last;
    logic                    w_accept;
    logic [c_slot_w-1:0]     w_start_slot;
    logic [31:0]             w_inst;

    assign out_valid = (r_state == ST_ISSUE);
    assign w_fire    = out_valid && out_ready;
    assign w_last    = (r_slot == c_last_slot);
    // Taking a new bundle in the final-slot handshake cycle avoids a bubble.
    assign in_ready  = !flush && ((r_state == ST_IDLE) || (w_fire && w_last));
    assign w_accept  = in_valid && in_ready;

    generate
        if (c_slots > 1) begin : g_multi_slot
            assign w_start_slot = in_pc[c_off_w-1:2];
            assign w_inst       = r_bundle[{r_slot, 5'd0} +: 32];
        end else begin : g_single_slot
            assign w_start_slot = '0;
            assign w_inst       = r_bundle[31:0];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (flush) begin
            w_state_next = ST_IDLE;
        end else if (w_accept) begin
            w_state_next = ST_ISSUE;
        end else if (w_fire && w_last) begin
            w_state_next = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bundle <= '0;
            r_base   <= '0;
            r_slot   <= '0;
        end else if (w_accept) begin
            r_bundle <= in_bundle;
            r_base   <= in_pc & c_base_mask;
            r_slot   <= w_start_slot;
        end else if (w_fire && !w_last && !flush) begin
            r_slot   <= r_slot + c_slot_one;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (w_fire && !flush) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign decoded_count = r_count;

    // Instruction field decode
    logic [6:0]         w_opcode;
    logic [2:0]         w_funct3;
    logic [6:0]         w_funct7;
    logic [5:0]         w_top6;
    logic               w_shamt_ok;
    logic signed [31:0] w_imm_i;
    logic signed [31:0] w_imm_s;
    logic signed [31:0] w_imm_b;
    logic signed [31:0] w_imm_u;
    logic signed [31:0] w_imm_j;
    logic [3:0]         w_class;
    logic [XLEN-1:0]    w_imm;
    logic               w_legal;

    assign w_opcode   = w_inst[6:0];
    assign w_funct3   = w_inst[14:12];
    assign w_funct7   = w_inst[31:25];
    assign w_top6     = w_inst[31:26];
    assign w_shamt_ok = c_rv64 || !w_inst[25];

    assign w_imm_i = {{20{w_inst[31]}}, w_inst[31:20]};
    assign w_imm_s = {{20{w_inst[31]}}, w_inst[31:25], w_inst[11:7]};
    assign w_imm_b = {{19{w_inst[31]}}, w_inst[31], w_inst[7], w_inst[30:25], w_inst[11:8], 1'b0};
    assign w_imm_u = {w_inst[31:12], 12'd0};
    assign w_imm_j = {{11{w_inst[31]}}, w_inst[31], w_inst[19:12], w_inst[20], w_inst[30:21], 1'b0};

    // A full 7-bit opcode match also rejects inst[1:0] != 2'b11.
    always_comb begin
        w_class = c_cls_none;
        w_imm   = '0;
        w_legal = 1'b0;
        case (w_opcode)
            7'b0110111: begin w_class = 4'd0;  w_imm = XLEN'(w_imm_u); w_legal = 1'b1; end
            7'b0010111: begin w_class = 4'd1;  w_imm = XLEN'(w_imm_u); w_legal = 1'b1; end
            7'b1101111: begin w_class = 4'd2;  w_imm = XLEN'(w_imm_j); w_legal = 1'b1; end
            7'b1100111: begin
                w_class = 4'd3;  w_imm = XLEN'(w_imm_i);
                w_legal = (w_funct3 == 3'b000);
            end
            7'b1100011: begin
                w_class = 4'd4;  w_imm = XLEN'(w_imm_b);
                w_legal = (w_funct3 != 3'b010) && (w_funct3 != 3'b011);
            end
            7'b0000011: begin
                w_class = 4'd5;  w_imm = XLEN'(w_imm_i);
                w_legal = (w_funct3 != 3'b111) &&
                          (c_rv64 || ((w_funct3 != 3'b011) && (w_funct3 != 3'b110)));
            end
            7'b0100011: begin
                w_class = 4'd6;  w_imm = XLEN'(w_imm_s);
                w_legal = !w_funct3[2] && (c_rv64 || (w_funct3 != 3'b011));
            end
            7'b0010011: begin
                w_class = 4'd7;  w_imm = XLEN'(w_imm_i);
                case (w_funct3)
                    3'b001:  w_legal = (w_top6 == 6'b000000) && w_shamt_ok;
                    3'b101:  w_legal = ((w_top6 == 6'b000000) || (w_top6 == 6'b010000)) && w_shamt_ok;
                    default: w_legal = 1'b1;
                endcase
            end
            7'b0110011: begin
                w_class = 4'd8;
                w_legal = (w_funct7 == 7'b0000000) ||
                          ((w_funct7 == 7'b0100000) && ((w_funct3 == 3'b000) || (w_funct3 == 3'b101)));
            end
            7'b0011011: begin w_class = 4'd9;  w_imm = XLEN'(w_imm_i); w_legal = c_rv64; end
            7'b0111011: begin w_class = 4'd10; w_legal = c_rv64; end
            7'b0001111: begin w_class = 4'd11; w_imm = XLEN'(w_imm_i); w_legal = 1'b1; end
            7'b1110011: begin w_class = 4'd12; w_imm = XLEN'(w_imm_i); w_legal = 1'b1; end
            default:    begin w_class = c_cls_none; w_legal = 1'b0; end
        endcase
        if (!w_legal) begin
            w_class = c_cls_none;
            w_imm   = '0;
        end
    end

    // Decode outputs read as zero (class "none") whenever nothing is issuing.
    assign out_pc      = out_valid ? (r_base + XLEN'({r_slot, 2'b00})) : '0;
    assign out_inst    = out_valid ? w_inst : 32'd0;
    assign out_rd      = out_valid ? w_inst[11:7]  : 5'd0;
    assign out_rs1     = out_valid ? w_inst[19:15] : 5'd0;
    assign out_rs2     = out_valid ? w_inst[24:20] : 5'd0;
    assign out_funct3  = out_valid ? w_funct3 : 3'd0;
    assign out_alt     = out_valid && w_inst[30];
    assign out_imm     = out_valid ? w_imm : '0;
    assign out_class   = out_valid ? w_class : c_cls_none;
    assign out_illegal = out_valid && !w_legal;

`ifdef DECODE_TRACE_EN
    function automatic string mnemonic(input logic [3:0] cls, input logic [2:0] f3, input logic alt);
        string br [8] = '{"BEQ", "BNE", "?", "?", "BLT", "BGE", "BLTU", "BGEU"};
        string ld [8] = '{"LB", "LH", "LW", "LD", "LBU", "LHU", "LWU", "?"};
        string st [8] = '{"SB", "SH", "SW", "SD", "?", "?", "?", "?"};
        string oi [8] = '{"ADDI", "SLLI", "SLTI", "SLTIU", "XORI", "SRLI", "ORI", "ANDI"};
        string rr [8] = '{"ADD", "SLL", "SLT", "SLTU", "XOR", "SRL", "OR", "AND"};
        case (cls)
            4'd0:    return "LUI";
            4'd1:    return "AUIPC";
            4'd2:    return "JAL";
            4'd3:    return "JALR";
            4'd4:    return br[f3];
            4'd5:    return ld[f3];
            4'd6:    return st[f3];
            4'd7:    return (f3 == 3'b101 && alt) ? "SRAI" : oi[f3];
            4'd8:    return alt ? ((f3 == 3'b000) ? "SUB" : "SRA") : rr[f3];
            4'd9:    return (f3 == 3'b000) ? "ADDIW" : (f3 == 3'b001) ? "SLLIW" : (alt ? "SRAIW" : "SRLIW");
            4'd10:   return (f3 == 3'b000) ? (alt ? "SUBW" : "ADDW") : (f3 == 3'b001) ? "SLLW" : (alt ? "SRAW" : "SRLW");
            4'd11:   return "FENCE";
            4'd12:   return "SYSTEM";
            default: return "ILLEGAL";
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (!reset && !flush && w_fire) begin
            $display("decode_stage: count=%0d pc=0x%h %s", r_count + CNT_W'(1), out_pc,
                     mnemonic(out_class, out_funct3, out_alt));
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_stage
// Purpose  : Self-checking bench for decode_stage (XLEN=64, two-slot bundles).
// Revision : 1.0
// ============================================================================
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [63:0] in_bundle, in_pc, out_pc, out_imm;
    logic [31:0] out_inst, decoded_count;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic [3:0]  out_class;
    logic [2:0]  out_funct3;
    logic        out_alt, out_illegal;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_count = 32'd0;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
    } item_t;
    item_t q[$];

    logic [6:0] ops [13] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23,
                             7'h13, 7'h33, 7'h1B, 7'h3B, 7'h0F, 7'h73};

    always #5 clk = ~clk;

    decode_stage dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_bundle(in_bundle), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
        .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm(out_imm),
        .out_class(out_class), .out_funct3(out_funct3), .out_alt(out_alt),
        .out_illegal(out_illegal), .decoded_count(decoded_count)
    );

    // RV64I reference decode built from signed arithmetic on the instruction word.
    function automatic void ref_decode(input logic [31:0] inst, output logic [3:0] cls,
                                       output logic [63:0] imm, output logic ill);
        int     op, f3, f7, top6;
        longint si, hi, imm_i, imm_s, imm_b, imm_u, imm_j;
        bit     ok;
        op    = int'(inst[6:0]);
        f3    = int'(inst[14:12]);
        f7    = int'(inst[31:25]);
        top6  = int'(inst[31:26]);
        si    = $signed(inst);
        hi    = si >>> 31;
        imm_i = si >>> 20;
        imm_s = (si >>> 25) * 32 + int'(inst[11:7]);
        imm_b = hi * 4096 + int'(inst[7]) * 2048 + int'(inst[30:25]) * 32 + int'(inst[11:8]) * 2;
        imm_u = (si >>> 12) * 4096;
        imm_j = hi * 1048576 + int'(inst[19:12]) * 4096 + int'(inst[20]) * 2048 + int'(inst[30:21]) * 2;
        ok  = 1'b1;
        imm = 64'd0;
        cls = 4'd15;
        case (op)
            'h37: begin cls = 4'd0;  imm = imm_u; end
            'h17: begin cls = 4'd1;  imm = imm_u; end
            'h6F: begin cls = 4'd2;  imm = imm_j; end
            'h67: begin cls = 4'd3;  imm = imm_i; ok = (f3 == 0); end
            'h63: begin cls = 4'd4;  imm = imm_b; ok = (f3 != 2) && (f3 != 3); end
            'h03: begin cls = 4'd5;  imm = imm_i; ok = (f3 != 7); end
            'h23: begin cls = 4'd6;  imm = imm_s; ok = (f3 < 4); end
            'h13: begin
                cls = 4'd7; imm = imm_i;
                if (f3 == 1)      ok = (top6 == 0);
                else if (f3 == 5) ok = (top6 == 0) || (top6 == 16);
            end
            'h33: begin cls = 4'd8;  ok = (f7 == 0) || (f7 == 32 && (f3 == 0 || f3 == 5)); end
            'h1B: begin cls = 4'd9;  imm = imm_i; end
            'h3B: begin cls = 4'd10; end
            'h0F: begin cls = 4'd11; imm = imm_i; end
            'h73: begin cls = 4'd12; imm = imm_i; end
            default: ok = 1'b0;
        endcase
        ill = !ok;
        if (!ok) begin
            cls = 4'd15;
            imm = 64'd0;
        end
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [31:0] w;
        int          pick;
        w    = $urandom;
        pick = $urandom_range(0, 9);
        if (pick < 8) w[6:0] = ops[$urandom_range(0, 12)];
        if (pick < 4) w[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
        return w;
    endfunction

    task automatic present(input logic [63:0] b, input logic [63:0] pc);
        in_valid  = 1'b1;
        in_bundle = b;
        in_pc     = pc;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_bundle = '0; in_pc = '0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({out_valid, in_ready, decoded_count, out_class, out_imm, out_pc, out_inst, out_illegal}
            !== {1'b0, 1'b1, 32'd0, 4'd15, 64'd0, 64'd0, 32'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: got v=%b rdy=%b cnt=%0d cls=%0d imm=%h pc=%h inst=%h ill=%b, expected v=0 rdy=1 cnt=0 cls=15 rest 0",
                     out_valid, in_ready, decoded_count, out_class, out_imm, out_pc, out_inst, out_illegal);
        end
        @(negedge clk);
        reset = 1'b0;
        exp_count = 32'd0;
    endtask

    task automatic test_basic();
        @(negedge clk);
        present(64'h00500093_00A00113, 64'h1000);
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_pc, out_class, out_rd, out_imm} !== {1'b1, 64'h1000, 4'd7, 5'd2, 64'd10}) begin
            errors++;
            $display("FAIL basic_slot0: got v=%b pc=%h cls=%0d rd=%0d imm=%h, expected v=1 pc=1000 cls=7 rd=2 imm=a",
                     out_valid, out_pc, out_class, out_rd, out_imm);
        end
        @(negedge clk);
        #1;
        checks++;
        if ({out_valid, out_pc, out_rd, out_imm, in_ready} !== {1'b1, 64'h1004, 5'd1, 64'd5, 1'b1}) begin
            errors++;
            $display("FAIL basic_slot1: got v=%b pc=%h rd=%0d imm=%h in_ready=%b, expected v=1 pc=1004 rd=1 imm=5 in_ready=1",
                     out_valid, out_pc, out_rd, out_imm, in_ready);
        end
        @(negedge clk);
        #1;
        exp_count += 2;
        checks++;
        if ({out_valid, decoded_count} !== {1'b0, exp_count}) begin
            errors++;
            $display("FAIL basic_done: got v=%b cnt=%0d, expected v=0 cnt=%0d", out_valid, decoded_count, exp_count);
        end
    endtask

    task automatic test_branch();
        @(negedge clk);
        present({32'h00000013, 32'hFE000EE3}, 64'h2000);
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++;
        if ({out_pc, out_class, out_funct3, out_imm, out_illegal}
            !== {64'h2000, 4'd4, 3'd0, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0}) begin
            errors++;
            $display("FAIL branch_imm: got pc=%h cls=%0d f3=%0d imm=%h ill=%b, expected pc=2000 cls=4 f3=0 imm=fffffffffffffffc ill=0",
                     out_pc, out_class, out_funct3, out_imm, out_illegal);
        end
        repeat (2) @(negedge clk);
        #1;
        exp_count += 2;
        checks++;
        if ({out_valid, decoded_count} !== {1'b0, exp_count}) begin
            errors++;
            $display("FAIL branch_done: got v=%b cnt=%0d, expected v=0 cnt=%0d", out_valid, decoded_count, exp_count);
        end
    endtask

    task automatic test_start_slot();
        @(negedge clk);
        present({32'h0000A083, 32'hFFFF_FFFF}, 64'h3004);
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_pc, out_class, out_funct3, out_rd, out_rs1, out_illegal}
            !== {1'b1, 64'h3004, 4'd5, 3'b010, 5'd1, 5'd1, 1'b0}) begin
            errors++;
            $display("FAIL start_slot: got v=%b pc=%h cls=%0d f3=%0d rd=%0d rs1=%0d ill=%b, expected v=1 pc=3004 cls=5 f3=2 rd=1 rs1=1 ill=0",
                     out_valid, out_pc, out_class, out_funct3, out_rd, out_rs1, out_illegal);
        end
        @(negedge clk);
        #1;
        exp_count += 1;
        checks++;
        if ({out_valid, decoded_count} !== {1'b0, exp_count}) begin
            errors++;
            $display("FAIL start_slot_done: got v=%b cnt=%0d, expected v=0 cnt=%0d", out_valid, decoded_count, exp_count);
        end
    endtask

    task automatic test_illegal();
        @(negedge clk);
        present({32'h0070F0B3, 32'h00000000}, 64'h9000);
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_illegal, out_class, out_imm} !== {1'b1, 1'b1, 4'd15, 64'd0}) begin
            errors++;
            $display("FAIL illegal_slot0: got v=%b ill=%b cls=%0d imm=%h, expected v=1 ill=1 cls=15 imm=0",
                     out_valid, out_illegal, out_class, out_imm);
        end
        @(negedge clk);
        #1;
        checks++;
        if ({out_valid, out_illegal, out_class, out_funct3} !== {1'b1, 1'b0, 4'd8, 3'd7}) begin
            errors++;
            $display("FAIL illegal_slot1: got v=%b ill=%b cls=%0d f3=%0d, expected v=1 ill=0 cls=8 f3=7",
                     out_valid, out_illegal, out_class, out_funct3);
        end
        @(negedge clk);
        #1;
        exp_count += 2;
        checks++;
        if ({out_valid, decoded_count} !== {1'b0, exp_count}) begin
            errors++;
            $display("FAIL illegal_done: got v=%b cnt=%0d, expected v=0 cnt=%0d", out_valid, decoded_count, exp_count);
        end
    endtask

    task automatic test_stall();
        @(negedge clk);
        present(64'h00500093_00A00113, 64'h4000);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            checks++;
            if ({out_valid, out_pc, out_inst, out_imm, decoded_count}
                !== {1'b1, 64'h4000, 32'h00A00113, 64'd10, exp_count}) begin
                errors++;
                $display("FAIL stall_hold%0d: got v=%b pc=%h inst=%h imm=%h cnt=%0d, expected v=1 pc=4000 inst=00a00113 imm=a cnt=%0d",
                         i, out_valid, out_pc, out_inst, out_imm, decoded_count, exp_count);
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if ({out_valid, out_pc, out_inst, decoded_count} !== {1'b1, 64'h4004, 32'h00500093, exp_count + 32'd1}) begin
            errors++;
            $display("FAIL stall_release: got v=%b pc=%h inst=%h cnt=%0d, expected v=1 pc=4004 inst=00500093 cnt=%0d",
                     out_valid, out_pc, out_inst, decoded_count, exp_count + 32'd1);
        end
        @(negedge clk);
        exp_count += 2;
    endtask

    task automatic test_flush();
        @(negedge clk);
        present(64'h00500093_00A00113, 64'h5000);
        out_ready = 1'b0;
        @(negedge clk);
        flush = 1'b1;
        out_ready = 1'b1;
        present({32'h0000A083, 32'h00000013}, 64'h6004);
        #1;
        checks++;
        if ({out_valid, out_pc, in_ready} !== {1'b1, 64'h5000, 1'b0}) begin
            errors++;
            $display("FAIL flush_cycle: got v=%b pc=%h in_ready=%b, expected v=1 pc=5000 in_ready=0",
                     out_valid, out_pc, in_ready);
        end
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        #1;
        checks++;
        if ({out_valid, decoded_count} !== {1'b0, exp_count}) begin
            errors++;
            $display("FAIL flush_after: got v=%b cnt=%0d, expected v=0 cnt=%0d", out_valid, decoded_count, exp_count);
        end
        @(negedge clk);
        present({32'h0000A083, 32'h00000013}, 64'h6004);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_pc, out_inst, out_class} !== {1'b1, 64'h6004, 32'h0000A083, 4'd5}) begin
            errors++;
            $display("FAIL flush_reissue: got v=%b pc=%h inst=%h cls=%0d, expected v=1 pc=6004 inst=0000a083 cls=5",
                     out_valid, out_pc, out_inst, out_class);
        end
        @(negedge clk);
        exp_count += 1;
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        present(64'h00500093_00A00113, 64'h7000);
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        present({32'h0070F0B3, 32'h00A00113}, 64'h8000);
        #1;
        checks++;
        if ({out_pc, in_ready} !== {64'h7004, 1'b1}) begin
            errors++;
            $display("FAIL b2b_ready: got pc=%h in_ready=%b, expected pc=7004 in_ready=1", out_pc, in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_pc, decoded_count} !== {1'b1, 64'h8000, exp_count + 32'd2}) begin
            errors++;
            $display("FAIL b2b_no_bubble: got v=%b pc=%h cnt=%0d, expected v=1 pc=8000 cnt=%0d",
                     out_valid, out_pc, decoded_count, exp_count + 32'd2);
        end
        repeat (2) @(negedge clk);
        exp_count += 4;
    endtask

    task automatic test_random();
        item_t       it;
        logic [3:0]  ecls;
        logic [63:0] eimm, base;
        logic        eill, exp_valid, exp_ready;
        q.delete();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            in_valid  = ($urandom_range(0, 1) != 0);
            in_bundle = {rand_inst(), rand_inst()};
            in_pc     = {$urandom, $urandom} & ~64'h3;
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            #1;
            exp_valid = (q.size() != 0);
            exp_ready = !flush && (q.size() == 0 || (q.size() == 1 && out_ready));
            checks++;
            if ({out_valid, in_ready, decoded_count} !== {exp_valid, exp_ready, exp_count}) begin
                errors++;
                $display("FAIL rand_ctrl cyc %0d: got v=%b rdy=%b cnt=%0d, expected v=%b rdy=%b cnt=%0d",
                         cyc, out_valid, in_ready, decoded_count, exp_valid, exp_ready, exp_count);
            end
            if (exp_valid) begin
                it = q[0];
                ref_decode(it.inst, ecls, eimm, eill);
                checks++;
                if ({out_pc, out_inst, out_class, out_imm, out_illegal, out_rd, out_rs1, out_rs2, out_funct3, out_alt}
                    !== {it.pc, it.inst, ecls, eimm, eill, it.inst[11:7], it.inst[19:15], it.inst[24:20],
                         it.inst[14:12], it.inst[30]}) begin
                    errors++;
                    $display("FAIL rand_decode cyc %0d inst %h: got pc=%h cls=%0d imm=%h ill=%b rd=%0d rs1=%0d rs2=%0d, expected pc=%h cls=%0d imm=%h ill=%b",
                             cyc, it.inst, out_pc, out_class, out_imm, out_illegal, out_rd, out_rs1, out_rs2,
                             it.pc, ecls, eimm, eill);
                end
            end else begin
                checks++;
                if ({out_class, out_imm} !== {4'd15, 64'd0}) begin
                    errors++;
                    $display("FAIL rand_idle cyc %0d: got cls=%0d imm=%h, expected cls=15 imm=0", cyc, out_class, out_imm);
                end
            end
            if (flush) begin
                q.delete();
            end else begin
                if (exp_valid && out_ready) begin
                    void'(q.pop_front());
                    exp_count++;
                end
                if (in_valid && exp_ready) begin
                    base = in_pc & ~64'h7;
                    for (int k = int'(in_pc[2]); k < 2; k++) begin
                        it.pc   = base + 64'(4 * k);
                        it.inst = in_bundle[32*k +: 32];
                        q.push_back(it);
                    end
                end
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_branch();
        test_start_slot();
        test_illegal();
        test_stall();
        test_flush();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
